pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of GROUP and at least GROUP.
REQ-002 Parameter GROUP, default 4: bits per carry-lookahead group; one pipeline stage per group.
REQ-003 Derived constant L = WIDTH/GROUP SHALL be the pipeline depth in stages.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block accepts an operand set this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in; used in add mode only.
REQ-011 mode  input  1  0 = add, 1 = subtract.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out of the MSB; in subtract mode, 1 = no borrow.
REQ-016 ovf  output  1  two's-complement signed overflow.
REQ-017 zero  output  1  sum == 0.

Function
REQ-018 Add mode SHALL compute {cout,sum} = a + b + cin.
REQ-019 Subtract mode SHALL compute a + ~b + 1; cin SHALL be ignored.
REQ-020 Within each group, carries SHALL use per-bit generate (a&b') and propagate (a^b') terms with lookahead, where b' is the mode-conditioned B; sum bit = p ^ carry.
REQ-021 Stage k SHALL resolve group k only, using the carry registered by stage k-1 (stage 0 uses the mode-selected carry-in).
REQ-022 Operand bits for groups above k and result bits for groups below k SHALL be carried forward in the stage registers (skewed pipeline); mode SHALL travel with the data.
REQ-023 Accept condition: in_valid & in_ready at a rising edge.
REQ-024 Global advance signal adv = !out_valid | out_ready; in_ready SHALL equal adv.
REQ-025 When adv = 0, every stage register, including its valid bit, SHALL hold.
REQ-026 When adv = 1, every stage SHALL shift by one; a stage whose predecessor holds no valid data SHALL become invalid (bubble).
REQ-027 Latency: with no stall, a set accepted in cycle t SHALL appear with out_valid = 1 in cycle t+L.
REQ-028 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-029 Results SHALL leave in acceptance order, with none dropped or duplicated under any out_ready pattern.
REQ-030 sum, cout, ovf and zero SHALL be registered outputs, stable while out_valid = 1 and out_ready = 0.
REQ-031 ovf SHALL equal (carry into MSB) XOR cout; zero SHALL be computed from the final sum.
REQ-032 When out_valid = 0, data outputs SHALL hold their last value; their content is don't-care.

Reset
REQ-033 When rst_n = 0 at a rising edge, all stage valid bits, out_valid, sum, cout, ovf and zero SHALL become 0.
REQ-034 A reset during operation SHALL discard all in-flight sets with no partial result emitted.
REQ-035 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-036 The MODE_ADD = 0 and MODE_SUB = 1 encodings SHALL live in a shared package, cla_pkg.
REQ-037 A combinational sub-module, cla_group (GROUP-wide p/g, lookahead carries, sum, group carry-out), SHALL be instantiated once per stage via generate.
REQ-038 The block SHALL contain no combinational path from in_valid or operands to any output; out_ready to in_ready is the only combinational path.

Verification (WIDTH = 16, GROUP = 4, L = 4)
REQ-039 Add 0xFFFF + 0x0001, cin = 0 -> sum 0x0000, cout 1, zero 1, ovf 0, exactly 4 cycles after acceptance.
REQ-040 Add 0x7FFF + 0x0001, cin = 0 -> sum 0x8000, cout 0, ovf 1; add 0x1234 + 0x0000, cin = 1 -> sum 0x1235.
REQ-041 Subtract 0x0005 - 0x0007 (cin = 1, ignored) -> sum 0xFFFE, cout 0, ovf 0; subtract 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1.
REQ-042 Stream 10 sets back-to-back with out_ready held low for 3 cycles mid-stream -> in_ready low in those cycles, outputs held stable, all 10 results in order matching a reference model.
REQ-043 Drive rst_n low for 1 cycle while 3 sets are in flight -> out_valid 0 the next cycle, no stale result ever appears, and a new set accepted afterwards appears 4 cycles later.
REQ-044 Run 10k random operand/mode/cin sets with random in_valid/out_ready -> every result matches the reference model, including cout/ovf/zero; repeat with WIDTH = 32, GROUP = 8.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared encodings and small helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Carry into bit 0: subtraction forms a + ~b + 1, so the external carry-in is ignored.
  function automatic logic stage0_carry(input logic mode, input logic cin);
    return (mode == MODE_SUB) ? 1'b1 : cin;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One carry-lookahead group: per-bit propagate/generate, lookahead carries,
// sum bits and group carry-out. Purely combinational.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  genvar gi;
  generate
    for (gi = 0; gi <= GROUP; gi++) begin : g_carry
      logic carry;

      // Carry into bit gi as a flat sum of products: cin or any lower generate
      // whose path up to gi fully propagates.
      always_comb begin
        logic term;
        term = cin;
        for (int m = 0; m < gi; m++) term = term & p[m];
        carry = term;
        for (int j = 0; j < gi; j++) begin
          term = g[j];
          for (int m = j + 1; m < gi; m++) term = term & p[m];
          carry = carry | term;
        end
      end

      assign c[gi] = carry;
    end
  endgenerate

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Skewed pipelined adder/subtractor: stage k resolves lookahead group k using
// the carry registered by stage k-1. The partial word rotates right by one
// group per stage, so the group being resolved always sits in the low bits and
// finished sum groups accumulate from the top; after WIDTH/GROUP stages the
// word is the aligned sum. B rotates the same way and mode travels alongside.
module pipe_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int L = WIDTH / GROUP;

  logic adv;

  // Element k is what stage k consumes; element k+1 is driven by stage k's registers.
  logic             src_valid [L+1];
  logic [WIDTH-1:0] src_word  [L+1];
  logic             src_carry [L+1];
  logic [WIDTH-1:0] src_b     [L];
  logic             src_mode  [L];

  assign src_valid[0] = in_valid;
  assign src_word[0]  = a;
  assign src_carry[0] = stage0_carry(mode, cin);
  assign src_b[0]     = b;
  assign src_mode[0]  = mode;

  // One global advance: the whole pipe moves or the whole pipe holds.
  assign out_valid = src_valid[L];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign sum       = src_word[L];
  assign cout      = src_carry[L];

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_stage
      logic [GROUP-1:0] grp_a;
      logic [GROUP-1:0] grp_b;
      logic [GROUP-1:0] grp_sum;
      logic             grp_cout;
      logic [WIDTH-1:0] word_next;
      logic             valid_reg;
      logic [WIDTH-1:0] word_reg;
      logic             carry_reg;

      assign grp_a = src_word[gi][GROUP-1:0];
      assign grp_b = src_b[gi][GROUP-1:0] ^ {GROUP{src_mode[gi] == MODE_SUB}};

      cla_group #(.GROUP(GROUP)) u_group (
        .a    (grp_a),
        .b    (grp_b),
        .cin  (src_carry[gi]),
        .sum  (grp_sum),
        .cout (grp_cout)
      );

      if (L > 1) begin : g_rot
        assign word_next = {grp_sum, src_word[gi][WIDTH-1:GROUP]};
      end else begin : g_single
        assign word_next = grp_sum;
      end

      // Stage valid, rotated partial word and group carry-out; hold on stall.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          word_reg  <= '0;
          carry_reg <= 1'b0;
        end else if (adv) begin
          valid_reg <= src_valid[gi];
          word_reg  <= word_next;
          carry_reg <= grp_cout;
        end
      end

      assign src_valid[gi+1] = valid_reg;
      assign src_word[gi+1]  = word_reg;
      assign src_carry[gi+1] = carry_reg;

      if (gi < L - 1) begin : g_fwd
        logic [WIDTH-1:0] b_reg;
        logic             mode_reg;

        // Remaining B groups and the mode bit travel with the data.
        always_ff @(posedge clk) begin
          if (adv) begin
            b_reg    <= {{GROUP{1'b0}}, src_b[gi][WIDTH-1:GROUP]};
            mode_reg <= src_mode[gi];
          end
        end

        assign src_b[gi+1]    = b_reg;
        assign src_mode[gi+1] = mode_reg;
      end else begin : g_last
        logic ovf_reg;
        logic zero_reg;

        // Flags of the final stage; carry into the MSB is recovered as sum ^ a ^ b'.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
          end else if (adv) begin
            ovf_reg  <= grp_sum[GROUP-1] ^ grp_a[GROUP-1] ^ grp_b[GROUP-1] ^ grp_cout;
            zero_reg <= (word_next == '0);
          end
        end

        assign ovf  = ovf_reg;
        assign zero = zero_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Bench for pipe_cla_addsub: directed table with hand-computed results and
// latency, a stalled stream, a mid-flight reset, and random traffic on a
// 16/4 and a 32/8 instance against an arithmetic reference model.
module tb_pipe_cla_addsub;

  logic clk;
  logic rst_n;

  logic        in_valid16, in_ready16, cin16, mode16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cout16, ovf16, zero16;

  logic        in_valid32, in_ready32, cin32, mode32, out_valid32, out_ready32;
  logic [31:0] a32, b32, sum32;
  logic        cout32, ovf32, zero32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_q16[$];
  logic [34:0] exp_q32[$];

  pipe_cla_addsub #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .mode(mode16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  pipe_cla_addsub #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32), .mode(mode32), .out_valid(out_valid32),
    .out_ready(out_ready32), .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Result packed as {ovf, zero, cout, sum[31:0]} for a w-bit datapath.
  function automatic logic [34:0] ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                            input logic cv, input logic mv);
    logic [32:0] mask, full;
    logic [31:0] aa, bb, s;
    logic        c0, co, ov, z;
    mask = (33'd1 << w) - 33'd1;
    aa   = av & mask[31:0];
    bb   = (mv ? ~bv : bv) & mask[31:0];
    c0   = mv ? 1'b1 : cv;
    full = {1'b0, aa} + {1'b0, bb} + {32'd0, c0};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    z    = (s == 32'd0);
    return {ov, z, co, s};
  endfunction

  function automatic logic [31:0] pick_op(input int w);
    logic [32:0] mask;
    mask = (33'd1 << w) - 33'd1;
    case ($urandom_range(7))
      0:       return 32'd0;
      1:       return mask[31:0];
      2:       return 32'd1 << (w - 1);
      3:       return (32'd1 << (w - 1)) - 32'd1;
      default: return $urandom & mask[31:0];
    endcase
  endfunction

  // One cycle on instance sel (0 = 16-bit, 1 = 32-bit): drive at the falling
  // edge, then score the handshakes that the next rising edge will complete.
  task automatic step(input int sel, input logic iv, input logic [31:0] av, input logic [31:0] bv,
                      input logic cv, input logic mv, input logic orr,
                      output logic accepted, output logic popped);
    logic        ov, irdy, have;
    logic [34:0] got, exp;
    @(negedge clk);
    if (sel == 0) begin
      in_valid16 = iv; a16 = av[15:0]; b16 = bv[15:0]; cin16 = cv; mode16 = mv; out_ready16 = orr;
    end else begin
      in_valid32 = iv; a32 = av; b32 = bv; cin32 = cv; mode32 = mv; out_ready32 = orr;
    end
    #1;
    if (sel == 0) begin
      ov = out_valid16; irdy = in_ready16; got = {ovf16, zero16, cout16, 16'd0, sum16};
    end else begin
      ov = out_valid32; irdy = in_ready32; got = {ovf32, zero32, cout32, sum32};
    end
    popped = ov && orr;
    if (popped) begin
      have = 1'b0;
      exp  = '0;
      if (sel == 0 && exp_q16.size() != 0) begin exp = exp_q16.pop_front(); have = 1'b1; end
      if (sel == 1 && exp_q32.size() != 0) begin exp = exp_q32.pop_front(); have = 1'b1; end
      if (have) check(sel == 0 ? "result16" : "result32", {29'd0, got}, {29'd0, exp});
      else begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_result (inst %0d): got %h, expected no result", sel, got);
      end
    end
    accepted = iv && irdy;
    if (accepted) begin
      if (sel == 0) exp_q16.push_back(ref_model(16, av, bv, cv, mv));
      else          exp_q32.push_back(ref_model(32, av, bv, cv, mv));
    end
  endtask

  // Single set on the 16-bit instance; returns cycles until out_valid (0 = none within 8).
  task automatic run_single(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                            input logic mv, output int lat);
    logic acc, pop;
    step(0, 1'b1, {16'd0, av}, {16'd0, bv}, cv, mv, 1'b1, acc, pop);
    check("accept", {63'd0, acc}, 64'd1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, pop);
      if (pop) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_random(input int sel, input int n);
    int          acc_n, cyc, w;
    logic        acc, pop, iv, orr;
    logic [31:0] av, bv;
    acc_n = 0;
    cyc   = 0;
    w     = (sel == 0) ? 16 : 32;
    while ((acc_n < n || (sel == 0 ? exp_q16.size() : exp_q32.size()) != 0) && cyc < 60000) begin
      iv  = (acc_n < n) && ($urandom_range(3) != 0);
      orr = ($urandom_range(3) != 0);
      av  = pick_op(w);
      bv  = pick_op(w);
      step(sel, iv, av, bv, 1'($urandom_range(1)), 1'($urandom_range(1)), orr, acc, pop);
      if (acc) acc_n++;
      cyc++;
    end
    check(sel == 0 ? "random16_accepted" : "random32_accepted", 64'(acc_n), 64'(n));
    check(sel == 0 ? "random16_drained" : "random32_drained",
          64'(sel == 0 ? exp_q16.size() : exp_q32.size()), 64'd0);
    $display("random run inst %0d: %0d sets in %0d cycles", sel, acc_n, cyc);
  endtask

  initial begin
    vec_t        tbl[12];
    int          lat, idx, npop;
    logic        acc, pop, orr;
    logic [31:0] sa, sb;
    logic [18:0] snap;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; mode16 = 1'b0; out_ready16 = 1'b1;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; mode32 = 1'b0; out_ready32 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_out_valid16", {63'd0, out_valid16}, 64'd0);
    check("reset_sum16",       {48'd0, sum16},       64'd0);
    check("reset_cout16",      {63'd0, cout16},      64'd0);
    check("reset_ovf16",       {63'd0, ovf16},       64'd0);
    check("reset_zero16",      {63'd0, zero16},      64'd0);
    check("reset_in_ready16",  {63'd0, in_ready16},  64'd1);
    check("reset_out_valid32", {63'd0, out_valid32}, 64'd0);

    // Directed table: hand-computed results, each exactly 4 cycles after acceptance.
    for (int i = 0; i < 12; i++) begin
      run_single(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode, lat);
      check("latency", 64'(lat), 64'd4);
      check("sum",  {48'd0, sum16},  {48'd0, tbl[i].sum});
      check("cout", {63'd0, cout16}, {63'd0, tbl[i].cout});
      check("ovf",  {63'd0, ovf16},  {63'd0, tbl[i].ovf});
      check("zero", {63'd0, zero16}, {63'd0, tbl[i].zero});
      $display("vec %0d: a=%h b=%h cin=%0d mode=%0d -> sum=%h cout=%0d ovf=%0d zero=%0d lat=%0d",
               i, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode, sum16, cout16, ovf16, zero16, lat);
    end

    // Ten back-to-back sets with out_ready low for cycles 6..8.
    idx  = 0;
    npop = 0;
    snap = '0;
    for (int c = 0; c < 60 && (idx < 10 || exp_q16.size() != 0); c++) begin
      orr = !(c >= 6 && c <= 8);
      sa  = 32'(16'(idx * 16'h1357 + 16'h0F0F));
      sb  = 32'(16'(idx * 16'h2468 + 16'h00F1));
      step(0, idx < 10, sa, sb, idx[1], idx[0], orr, acc, pop);
      if (c == 6) snap = {ovf16, zero16, cout16, sum16};
      if (c >= 6 && c <= 8) check("in_ready_stall", {63'd0, in_ready16}, 64'd0);
      if (c == 7 || c == 8) check("stall_hold", {45'd0, ovf16, zero16, cout16, sum16}, {45'd0, snap});
      if (pop) begin
        npop++;
        $display("stream result %0d: sum=%h cout=%0d ovf=%0d zero=%0d", npop, sum16, cout16, ovf16, zero16);
      end
      if (acc) idx++;
    end
    check("stream_accepts", 64'(idx), 64'd10);
    check("stream_results", 64'(npop), 64'd10);

    // Reset with three sets in flight: nothing of them may ever emerge.
    for (int c = 0; c < 3; c++) begin
      step(0, 1'b1, 32'(16'h1111 * (c + 1)), 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc, pop);
      check("inflight_accept", {63'd0, acc}, 64'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q16.delete();
    #1;
    check("post_reset_out_valid", {63'd0, out_valid16}, 64'd0);
    check("post_reset_in_ready",  {63'd0, in_ready16},  64'd1);
    for (int c = 0; c < 6; c++) begin
      step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, pop);
      check("no_stale", {63'd0, out_valid16}, 64'd0);
    end
    run_single(16'h4321, 16'h1234, 1'b0, 1'b0, lat);
    check("post_reset_latency", 64'(lat), 64'd4);
    check("post_reset_sum", {48'd0, sum16}, 64'h5555);
    $display("post-reset set: sum=%h lat=%0d", sum16, lat);

    // Random traffic on both geometries in parallel.
    fork
      run_random(0, 10000);
      run_random(1, 10000);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
